cnn_maxpool_2x2: RTL and testbench



---
 rtl/cnn_maxpool_2x2.sv | 125 ++++++++++++
 tb/tb_cnn_maxpool_2x2.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_maxpool_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered multi-channel feature map stream.
// One half-width row of horizontal pair maxima is buffered so the input never stalls.
module cnn_maxpool_2x2 #(
    parameter int CO     = 3,
    parameter int I_F_BW = 20,
    parameter int IX     = 24,
    parameter int IY     = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_in_valid,
    input  logic [CO*I_F_BW-1:0] i_in_fmap,
    output logic                 o_ot_valid,
    output logic [CO*I_F_BW-1:0] o_ot_fmap,
    output logic                 o_ot_last
);
    localparam int W  = CO * I_F_BW;
    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;
    localparam int HD = IX / 2;
    localparam int AW = (HD > 1) ? $clog2(HD) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IX - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IY - 1);

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    logic [W-1:0]  hold_q, hold_d;
    logic [W-1:0]  ot_fmap_q, ot_fmap_d;
    logic          ot_valid_q, ot_valid_d;
    logic          ot_last_q, ot_last_d;

    logic [W-1:0]  halfbuf [0:HD-1];
    logic [AW-1:0] hb_addr;
    logic [W-1:0]  hb_rd;
    logic          hb_we;
    logic [W-1:0]  pair_max;
    logic [W-1:0]  pool_max;

    logic col_odd, row_odd, col_end, row_end;

    assign col_odd = col_cnt_q[0];
    assign row_odd = row_cnt_q[0];
    assign col_end = (col_cnt_q == COL_LAST);
    assign row_end = (row_cnt_q == ROW_LAST);
    assign hb_addr = AW'(col_cnt_q >> 1);
    assign hb_rd   = halfbuf[hb_addr];
    assign hb_we   = i_in_valid && col_odd && !row_odd;

    // Per-channel unsigned compares: horizontal pair first, then against the buffered row above.
    genvar gi;
    generate
        for (gi = 0; gi < CO; gi++) begin : g_ch
            logic [I_F_BW-1:0] pix;
            logic [I_F_BW-1:0] hold;
            logic [I_F_BW-1:0] above;
            logic [I_F_BW-1:0] pmax;

            assign pix   = i_in_fmap[gi*I_F_BW +: I_F_BW];
            assign hold  = hold_q[gi*I_F_BW +: I_F_BW];
            assign above = hb_rd[gi*I_F_BW +: I_F_BW];
            assign pmax  = (pix > hold) ? pix : hold;

            assign pair_max[gi*I_F_BW +: I_F_BW] = pmax;
            assign pool_max[gi*I_F_BW +: I_F_BW] = (above > pmax) ? above : pmax;
        end
    endgenerate

    always_comb begin
        col_cnt_d  = col_cnt_q;
        row_cnt_d  = row_cnt_q;
        hold_d     = hold_q;
        ot_fmap_d  = ot_fmap_q;
        ot_valid_d = 1'b0;
        ot_last_d  = 1'b0;

        if (i_in_valid) begin
            if (col_end) begin
                col_cnt_d = '0;
                row_cnt_d = row_end ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end

            if (!col_odd) begin
                hold_d = i_in_fmap;
            end

            if (col_odd && row_odd) begin
                ot_valid_d = 1'b1;
                ot_fmap_d  = pool_max;
                ot_last_d  = col_end && row_end;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_cnt_q  <= '0;
            row_cnt_q  <= '0;
            hold_q     <= '0;
            ot_fmap_q  <= '0;
            ot_valid_q <= 1'b0;
            ot_last_q  <= 1'b0;
        end else begin
            col_cnt_q  <= col_cnt_d;
            row_cnt_q  <= row_cnt_d;
            hold_q     <= hold_d;
            ot_fmap_q  <= ot_fmap_d;
            ot_valid_q <= ot_valid_d;
            ot_last_q  <= ot_last_d;
        end
    end

    // Contents are always rewritten on an even row before the odd row reads them.
    always_ff @(posedge clk) begin
        if (hb_we) begin
            halfbuf[hb_addr] <= pair_max;
        end
    end

    assign o_ot_valid = ot_valid_q;
    assign o_ot_fmap  = ot_fmap_q;
    assign o_ot_last  = ot_last_q;

endmodule

// File: tb/tb_cnn_maxpool_2x2.sv
// Bench for cnn_maxpool_2x2: a small 4x4 single-channel instance and a default 24x24x3 instance,
// each checked beat-by-beat against a window-maximum reference model.
module tb_cnn_maxpool_2x2;
    localparam int CO = 3;
    localparam int BW = 20;
    localparam int IX = 24;
    localparam int IY = 24;
    localparam int W  = CO * BW;
    localparam int NPIX = IX * IY;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    logic          b_in_valid = 1'b0;
    logic [W-1:0]  b_in_fmap = '0;
    logic          b_ot_valid;
    logic [W-1:0]  b_ot_fmap;
    logic          b_ot_last;

    logic          s_in_valid = 1'b0;
    logic [BW-1:0] s_in_fmap = '0;
    logic          s_ot_valid;
    logic [BW-1:0] s_ot_fmap;
    logic          s_ot_last;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int lasts_seen = 0;
    int valids_seen = 0;

    logic [W-1:0] frame [IY][IX];
    logic [W-1:0] exp_hold = '0;

    always #5 clk = ~clk;

    cnn_maxpool_2x2 #(.CO(CO), .I_F_BW(BW), .IX(IX), .IY(IY)) u_big (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (b_in_valid),
        .i_in_fmap  (b_in_fmap),
        .o_ot_valid (b_ot_valid),
        .o_ot_fmap  (b_ot_fmap),
        .o_ot_last  (b_ot_last)
    );

    cnn_maxpool_2x2 #(.CO(1), .I_F_BW(BW), .IX(4), .IY(4)) u_small (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_in_valid (s_in_valid),
        .i_in_fmap  (s_in_fmap),
        .o_ot_valid (s_ot_valid),
        .o_ot_fmap  (s_ot_fmap),
        .o_ot_last  (s_ot_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: each pooled value is the largest of the four input pixels of its window, per channel.
    function automatic logic [W-1:0] pooled(input int py, input int px);
        logic [W-1:0]  r;
        logic [BW-1:0] m;
        logic [BW-1:0] v;
        r = '0;
        for (int c = 0; c < CO; c++) begin
            m = '0;
            for (int dy = 0; dy < 2; dy++) begin
                for (int dx = 0; dx < 2; dx++) begin
                    v = frame[2*py+dy][2*px+dx][c*BW +: BW];
                    if (v > m) m = v;
                end
            end
            r[c*BW +: BW] = m;
        end
        return r;
    endfunction

    task automatic big_beat(input int y, input int x);
        logic done;
        b_in_valid = 1'b1;
        b_in_fmap  = frame[y][x];
        @(posedge clk);
        #1;
        done = (y % 2 == 1) && (x % 2 == 1);
        if (done) begin
            exp_hold = pooled(y / 2, x / 2);
            check("out_valid", 64'(b_ot_valid), 64'(1));
            check("out_fmap", 64'(b_ot_fmap), 64'(exp_hold));
            check("out_last", 64'(b_ot_last), 64'((y == IY-1) && (x == IX-1)));
        end else begin
            check("idle_valid", 64'(b_ot_valid), 64'(0));
            check("idle_last", 64'(b_ot_last), 64'(0));
            check("hold_fmap", 64'(b_ot_fmap), 64'(exp_hold));
        end
        if (b_ot_valid === 1'b1) valids_seen++;
        if (b_ot_last === 1'b1) lasts_seen++;
        b_in_valid = 1'b0;
    endtask

    task automatic big_gap(input int n);
        for (int k = 0; k < n; k++) begin
            b_in_valid = 1'b0;
            b_in_fmap  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("gap_valid", 64'(b_ot_valid), 64'(0));
            check("gap_fmap", 64'(b_ot_fmap), 64'(exp_hold));
        end
    endtask

    task automatic send_frame(input int max_gap, input int n_beats);
        for (int i = 0; i < n_beats; i++) begin
            if (max_gap > 0) big_gap($urandom_range(1, max_gap));
            big_beat(i / IX, i % IX);
        end
    endtask

    task automatic fill_random(input int unsigned maxv);
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                for (int c = 0; c < CO; c++)
                    frame[y][x][c*BW +: BW] = BW'($urandom_range(0, maxv));
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic exp_v;
        int   p;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_big_valid", 64'(b_ot_valid), 64'(0));
        check("rst_big_last", 64'(b_ot_last), 64'(0));
        check("rst_big_fmap", 64'(b_ot_fmap), 64'(0));
        check("rst_small_valid", 64'(s_ot_valid), 64'(0));
        check("rst_small_last", 64'(s_ot_last), 64'(0));
        check("rst_small_fmap", 64'(s_ot_fmap), 64'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 4x4 ramp: windows complete on beats 5,7,13,15 with those values
        for (int i = 0; i < 16; i++) begin
            s_in_valid = 1'b1;
            s_in_fmap  = BW'(i);
            @(posedge clk);
            #1;
            exp_v = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            check("small_valid", 64'(s_ot_valid), 64'(exp_v));
            if (exp_v) check("small_fmap", 64'(s_ot_fmap), 64'(i));
            check("small_last", 64'(s_ot_last), 64'(i == 15));
        end
        s_in_valid = 1'b0;

        // Channel-independent patterns, no gaps
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++) begin
                p = y * IX + x;
                frame[y][x][0*BW +: BW] = BW'(p);
                frame[y][x][1*BW +: BW] = BW'(255 - (p & 255));
                frame[y][x][2*BW +: BW] = 20'hFFFFF;
            end
        lasts_seen = 0;
        valids_seen = 0;
        send_frame(0, NPIX);
        check("ramp_valids", 64'(valids_seen), 64'((IX/2)*(IY/2)));
        check("ramp_lasts", 64'(lasts_seen), 64'(1));

        // Random data with random 1-5 cycle gaps
        fill_random(20'hFFFFF);
        lasts_seen = 0;
        valids_seen = 0;
        send_frame(5, NPIX);
        check("gap_valids", 64'(valids_seen), 64'((IX/2)*(IY/2)));
        check("gap_lasts", 64'(lasts_seen), 64'(1));

        // Reset after 30 beats, then a fresh frame
        fill_random(20'hFFFFF);
        send_frame(0, 30);
        reset_n = 1'b0;
        #1;
        exp_hold = '0;
        check("mid_rst_valid", 64'(b_ot_valid), 64'(0));
        check("mid_rst_last", 64'(b_ot_last), 64'(0));
        check("mid_rst_fmap", 64'(b_ot_fmap), 64'(0));
        for (int k = 0; k < 3; k++) begin
            b_in_valid = 1'b1;
            b_in_fmap  = {$urandom, $urandom};
            @(posedge clk);
            #1;
            check("in_rst_valid", 64'(b_ot_valid), 64'(0));
        end
        b_in_valid = 1'b0;
        reset_n = 1'b1;
        fill_random(20'hFFFFF);
        lasts_seen = 0;
        valids_seen = 0;
        send_frame(0, NPIX);
        check("post_rst_valids", 64'(valids_seen), 64'((IX/2)*(IY/2)));
        check("post_rst_lasts", 64'(lasts_seen), 64'(1));

        // Two frames back-to-back, second = first + 1
        fill_random(20'hFFFFE);
        lasts_seen = 0;
        send_frame(0, NPIX);
        for (int y = 0; y < IY; y++)
            for (int x = 0; x < IX; x++)
                for (int c = 0; c < CO; c++)
                    frame[y][x][c*BW +: BW] = frame[y][x][c*BW +: BW] + 1'b1;
        send_frame(0, NPIX);
        check("b2b_lasts", 64'(lasts_seen), 64'(2));

        // Single hot pixel at each position of window (0,0)
        for (int pos = 0; pos < 4; pos++) begin
            for (int y = 0; y < IY; y++)
                for (int x = 0; x < IX; x++)
                    frame[y][x] = '0;
            for (int c = 0; c < CO; c++)
                frame[pos/2][pos%2][c*BW +: BW] = BW'(1);
            send_frame(0, NPIX);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
